// File: rtl/wb_stage_skid_reg_if.sv
// rtl/wb_stage_skid_reg_if.sv - handshake and payload bundle between MEM, the MEM/WB register and WB
interface wb_stage_skid_reg_if #(
  parameter int DATA_W = 32,
  parameter int DEST_W = 4
) ();
  logic              freeze;
  logic              flush;

  logic              in_valid;
  logic              in_ready;
  logic              in_wb_en;
  logic              in_mem_r_en;
  logic [DATA_W-1:0] in_alu_res;
  logic [DATA_W-1:0] in_data;
  logic [DEST_W-1:0] in_dest;

  logic              out_valid;
  logic              out_ready;
  logic              out_wb_en;
  logic              out_mem_r_en;
  logic [DATA_W-1:0] out_alu_res;
  logic [DATA_W-1:0] out_data;
  logic [DEST_W-1:0] out_dest;
  logic [DATA_W-1:0] out_wb_value;

  logic              fwd_en;
  logic [DEST_W-1:0] fwd_dest;
  logic [DATA_W-1:0] fwd_value;
  logic [1:0]        occupancy;

  modport master (
    output freeze, flush,
    output in_valid, in_wb_en, in_mem_r_en, in_alu_res, in_data, in_dest,
    output out_ready,
    input  in_ready,
    input  out_valid, out_wb_en, out_mem_r_en, out_alu_res, out_data, out_dest, out_wb_value,
    input  fwd_en, fwd_dest, fwd_value, occupancy
  );

  modport slave (
    input  freeze, flush,
    input  in_valid, in_wb_en, in_mem_r_en, in_alu_res, in_data, in_dest,
    input  out_ready,
    output in_ready,
    output out_valid, out_wb_en, out_mem_r_en, out_alu_res, out_data, out_dest, out_wb_value,
    output fwd_en, fwd_dest, fwd_value, occupancy
  );
endinterface

// File: rtl/wb_stage_skid_reg.sv
// rtl/wb_stage_skid_reg.sv - MEM->WB pipeline register with optional skid entry, freeze and flush
module wb_stage_skid_reg #(
  parameter int DATA_W = 32,
  parameter int DEST_W = 4,
  parameter int SKID   = 1
) (
  input logic                clk,
  input logic                rst,
  wb_stage_skid_reg_if.slave bus
);

  // state encoding doubles as the occupancy count
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;

  logic              r_main_wb_en;
  logic              r_main_mem_r_en;
  logic [DATA_W-1:0] r_main_alu_res;
  logic [DATA_W-1:0] r_main_data;
  logic [DEST_W-1:0] r_main_dest;

  logic              r_skid_wb_en;
  logic              r_skid_mem_r_en;
  logic [DATA_W-1:0] r_skid_alu_res;
  logic [DATA_W-1:0] r_skid_data;
  logic [DEST_W-1:0] r_skid_dest;

  logic              w_main_valid;
  logic              w_skid_valid;
  logic              w_in_ready;
  logic              w_accept;
  logic              w_deq;
  logic              w_load_main_in;
  logic              w_load_main_skid;
  logic              w_load_skid;
  logic              w_out_wb_en;
  logic [DATA_W-1:0] w_wb_value;

  assign w_main_valid = (r_state != ST_EMPTY);
  assign w_skid_valid = (r_state == ST_FULL);

  // with a skid entry, in_ready is registered state only, breaking the out_ready path
  generate
    if (SKID != 0) begin : g_skid
      assign w_in_ready = ~w_skid_valid & ~bus.freeze & ~bus.flush & ~rst;
    end else begin : g_noskid
      assign w_in_ready = (~w_main_valid | bus.out_ready) & ~bus.freeze & ~bus.flush & ~rst;
    end
  endgenerate

  assign w_accept = bus.in_valid & w_in_ready;
  assign w_deq    = w_main_valid & bus.out_ready & ~bus.freeze & ~bus.flush;

  always_comb begin
    w_state_nxt      = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_accept) begin
          w_state_nxt    = ST_ONE;
          w_load_main_in = 1'b1;
        end
      end
      ST_ONE: begin
        if (w_accept && w_deq) begin
          w_load_main_in = 1'b1;
        end else if (w_accept) begin
          w_state_nxt = ST_FULL;
          w_load_skid = 1'b1;
        end else if (w_deq) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (w_deq) begin
          w_state_nxt      = ST_ONE;
          w_load_main_skid = 1'b1;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  // freeze needs no branch here: it forces accept and deq low, so nothing loads
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      r_state         <= ST_EMPTY;
      r_main_wb_en    <= 1'b0;
      r_main_mem_r_en <= 1'b0;
      r_main_alu_res  <= '0;
      r_main_data     <= '0;
      r_main_dest     <= '0;
      r_skid_wb_en    <= 1'b0;
      r_skid_mem_r_en <= 1'b0;
      r_skid_alu_res  <= '0;
      r_skid_data     <= '0;
      r_skid_dest     <= '0;
    end else begin
      r_state <= w_state_nxt;

      if (w_load_main_in) begin
        r_main_wb_en    <= bus.in_wb_en;
        r_main_mem_r_en <= bus.in_mem_r_en;
        r_main_alu_res  <= bus.in_alu_res;
        r_main_data     <= bus.in_data;
        r_main_dest     <= bus.in_dest;
      end else if (w_load_main_skid) begin
        r_main_wb_en    <= r_skid_wb_en;
        r_main_mem_r_en <= r_skid_mem_r_en;
        r_main_alu_res  <= r_skid_alu_res;
        r_main_data     <= r_skid_data;
        r_main_dest     <= r_skid_dest;
      end

      if (w_load_skid) begin
        r_skid_wb_en    <= bus.in_wb_en;
        r_skid_mem_r_en <= bus.in_mem_r_en;
        r_skid_alu_res  <= bus.in_alu_res;
        r_skid_data     <= bus.in_data;
        r_skid_dest     <= bus.in_dest;
      end else if (w_load_main_skid) begin
        r_skid_wb_en    <= 1'b0;
        r_skid_mem_r_en <= 1'b0;
        r_skid_alu_res  <= '0;
        r_skid_data     <= '0;
        r_skid_dest     <= '0;
      end
    end
  end

  // control fields are gated so a bubble can never write the register file
  assign w_out_wb_en = r_main_wb_en & w_main_valid;
  assign w_wb_value  = r_main_mem_r_en ? r_main_data : r_main_alu_res;

  assign bus.in_ready     = w_in_ready;
  assign bus.out_valid    = w_main_valid;
  assign bus.out_wb_en    = w_out_wb_en;
  assign bus.out_mem_r_en = r_main_mem_r_en & w_main_valid;
  assign bus.out_alu_res  = r_main_alu_res;
  assign bus.out_data     = r_main_data;
  assign bus.out_dest     = r_main_dest;
  assign bus.out_wb_value = w_wb_value;
  assign bus.fwd_en       = w_out_wb_en;
  assign bus.fwd_dest     = r_main_dest;
  assign bus.fwd_value    = w_wb_value;
  assign bus.occupancy    = r_state;

  a_no_full_without_skid: assert property (@(posedge clk) disable iff (rst)
    (SKID != 0) || (r_state != ST_FULL));

endmodule

// File: tb/tb_wb_stage_skid_reg.sv
// tb/tb_wb_stage_skid_reg.sv - scoreboard bench for wb_stage_skid_reg (SKID=1 and SKID=0 instances)
module tb_wb_stage_skid_reg;

  typedef struct packed {
    logic        wb_en;
    logic        mem_r_en;
    logic [31:0] alu;
    logic [31:0] data;
    logic [3:0]  dest;
  } beat_t;

  logic  clk = 1'b0;
  logic  rst;
  int    n_tests = 0;
  int    n_fail  = 0;
  beat_t sb[$];

  wb_stage_skid_reg_if #(.DATA_W(32), .DEST_W(4)) bus1 ();
  wb_stage_skid_reg_if #(.DATA_W(32), .DEST_W(4)) bus0 ();

  wb_stage_skid_reg #(.DATA_W(32), .DEST_W(4), .SKID(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
  wb_stage_skid_reg #(.DATA_W(32), .DEST_W(4), .SKID(0)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive1(input logic v, input logic wb, input logic mr,
                        input logic [31:0] alu, input logic [31:0] dat, input logic [3:0] dst);
    bus1.in_valid = v; bus1.in_wb_en = wb; bus1.in_mem_r_en = mr;
    bus1.in_alu_res = alu; bus1.in_data = dat; bus1.in_dest = dst;
  endtask

  task automatic drive0(input logic v, input logic [31:0] alu, input logic [3:0] dst);
    bus0.in_valid = v; bus0.in_wb_en = 1'b1; bus0.in_mem_r_en = 1'b0;
    bus0.in_alu_res = alu; bus0.in_data = 32'h0; bus0.in_dest = dst;
  endtask

  // scoreboard monitor at the negedge, then advance to just after the next posedge
  task automatic step();
    beat_t e;
    @(negedge clk);
    if (rst || bus1.flush) begin
      sb.delete();
    end else begin
      if (bus1.out_valid && bus1.out_ready && !bus1.freeze) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          chk("sb_alu",      64'(bus1.out_alu_res),  64'(e.alu));
          chk("sb_data",     64'(bus1.out_data),     64'(e.data));
          chk("sb_dest",     64'(bus1.out_dest),     64'(e.dest));
          chk("sb_wb_en",    64'(bus1.out_wb_en),    64'(e.wb_en));
          chk("sb_mem_r_en", 64'(bus1.out_mem_r_en), 64'(e.mem_r_en));
          chk("sb_fwd_en",   64'(bus1.fwd_en),       64'(e.wb_en));
          chk("sb_fwd_dest", 64'(bus1.fwd_dest),     64'(e.dest));
          chk("sb_wb_value", 64'(bus1.out_wb_value), 64'(e.mem_r_en ? e.data : e.alu));
          chk("sb_fwd_val",  64'(bus1.fwd_value),    64'(e.mem_r_en ? e.data : e.alu));
        end
      end
      if (bus1.in_valid && bus1.in_ready)
        sb.push_back('{bus1.in_wb_en, bus1.in_mem_r_en, bus1.in_alu_res, bus1.in_data, bus1.in_dest});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bus1.in_valid  = 1'b0;
    bus1.out_ready = 1'b1;
    for (int i = 0; i < 10 && sb.size() != 0; i++) step();
    chk("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  function automatic logic [63:0] snap1();
    return {20'h0, bus1.in_ready, bus1.occupancy, bus1.out_valid, bus1.out_wb_en,
            bus1.fwd_en, bus1.out_dest, bus1.out_alu_res};
  endfunction

  initial begin
    logic [63:0] s;
    rst = 1'b1;
    bus1.freeze = 1'b0; bus1.flush = 1'b0; bus1.out_ready = 1'b0;
    bus0.freeze = 1'b0; bus0.flush = 1'b0; bus0.out_ready = 1'b0;
    drive1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive0(1'b0, 32'h0, 4'h0);
    #1;
    step();
    step();

    chk("rst_in_ready",  64'(bus1.in_ready),    64'd0);
    chk("rst_out_valid", 64'(bus1.out_valid),   64'd0);
    chk("rst_occ",       64'(bus1.occupancy),   64'd0);
    chk("rst_alu",       64'(bus1.out_alu_res), 64'd0);
    chk("rst_fwd_en",    64'(bus1.fwd_en),      64'd0);
    chk("rst_wb_value",  64'(bus1.out_wb_value), 64'd0);
    chk("rst_occ0",      64'(bus0.occupancy),   64'd0);
    rst = 1'b0;
    #1;
    chk("rel_in_ready",  64'(bus1.in_ready),    64'd1);
    chk("rel_in_ready0", 64'(bus0.in_ready),    64'd1);

    // streaming at full rate
    bus1.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive1(1'b1, 1'b1, 1'b0, 32'h10 + 32'(i), 32'h0, 4'(i + 1));
      step();
      chk("stream_alu",   64'(bus1.out_alu_res), 64'h10 + 64'(i));
      chk("stream_fdest", 64'(bus1.fwd_dest),    64'(i + 1));
      chk("stream_fen",   64'(bus1.fwd_en),      64'd1);
      chk("stream_occ",   64'(bus1.occupancy),   64'd1);
    end
    drive1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    step();
    chk("stream_idle_occ",  64'(bus1.occupancy), 64'd0);
    chk("stream_idle_wben", 64'(bus1.out_wb_en), 64'd0);

    // backpressure into the skid entry
    drive1(1'b1, 1'b1, 1'b0, 32'hA0, 32'h0, 4'h5); step();
    drive1(1'b1, 1'b1, 1'b0, 32'hA1, 32'h0, 4'h6); step();
    bus1.out_ready = 1'b0;
    drive1(1'b1, 1'b1, 1'b0, 32'hA2, 32'h0, 4'h7); step();
    chk("bp_occ",      64'(bus1.occupancy),   64'd2);
    chk("bp_in_ready", 64'(bus1.in_ready),    64'd0);
    chk("bp_main",     64'(bus1.out_alu_res), 64'hA1);
    drive1(1'b1, 1'b1, 1'b0, 32'hA3, 32'h0, 4'h8); step();
    chk("bp_hold_occ", 64'(bus1.occupancy),   64'd2);

    // freeze while FULL, even with out_ready high
    s = snap1();
    bus1.freeze = 1'b1;
    bus1.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("freeze_hold", snap1(), s);
    end
    bus1.freeze = 1'b0;
    for (int i = 0; i < 10 && !(bus1.in_valid && bus1.in_ready); i++) step();
    chk("bp_a3_ready", 64'(bus1.in_ready), 64'd1);
    step();
    drain();

    // write-back value mux
    drive1(1'b1, 1'b1, 1'b1, 32'h1234, 32'hBEEF, 4'h9); step();
    chk("mux_mem_wbv",  64'(bus1.out_wb_value), 64'hBEEF);
    chk("mux_mem_fwd",  64'(bus1.fwd_value),    64'hBEEF);
    drive1(1'b1, 1'b1, 1'b0, 32'h1234, 32'hBEEF, 4'h9); step();
    chk("mux_alu_wbv",  64'(bus1.out_wb_value), 64'h1234);
    chk("mux_alu_fwd",  64'(bus1.fwd_value),    64'h1234);
    drain();

    // flush beats freeze and a presented beat, discarding both entries
    bus1.out_ready = 1'b0;
    drive1(1'b1, 1'b1, 1'b1, 32'hB0, 32'hC0, 4'h1); step();
    drive1(1'b1, 1'b1, 1'b1, 32'hB1, 32'hC1, 4'h2); step();
    chk("fl_pre_occ", 64'(bus1.occupancy), 64'd2);
    drive1(1'b1, 1'b1, 1'b1, 32'hB2, 32'hC2, 4'h3);
    bus1.flush = 1'b1; bus1.freeze = 1'b1;
    step();
    bus1.flush = 1'b0; bus1.freeze = 1'b0;
    drive1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    #1;
    chk("fl_occ",   64'(bus1.occupancy),   64'd0);
    chk("fl_valid", 64'(bus1.out_valid),   64'd0);
    chk("fl_wb_en", 64'(bus1.out_wb_en),   64'd0);
    chk("fl_alu",   64'(bus1.out_alu_res), 64'd0);
    chk("fl_data",  64'(bus1.out_data),    64'd0);
    chk("fl_dest",  64'(bus1.out_dest),    64'd0);

    // reset mid-transfer
    drive1(1'b1, 1'b1, 1'b0, 32'hD0, 32'h0, 4'h4); step();
    rst = 1'b1; step();
    rst = 1'b0;
    drive1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    chk("rst_mid_valid", 64'(bus1.out_valid), 64'd0);
    chk("rst_mid_alu",   64'(bus1.out_alu_res), 64'd0);
    drain();

    // single-entry instance: in_ready follows out_ready combinationally
    bus0.out_ready = 1'b0;
    drive0(1'b1, 32'hC0, 4'h1); step();
    chk("s0_valid",    64'(bus0.out_valid),   64'd1);
    chk("s0_in_ready", 64'(bus0.in_ready),    64'd0);
    drive0(1'b1, 32'hC9, 4'h2); step();
    chk("s0_no_skid",  64'(bus0.occupancy),   64'd1);
    chk("s0_kept",     64'(bus0.out_alu_res), 64'hC0);
    bus0.out_ready = 1'b1;
    #1;
    chk("s0_in_ready1", 64'(bus0.in_ready),   64'd1);
    drive0(1'b1, 32'hC1, 4'h3); step();
    chk("s0_replace",  64'(bus0.out_alu_res), 64'hC1);
    chk("s0_rep_dest", 64'(bus0.out_dest),    64'd3);
    chk("s0_rep_occ",  64'(bus0.occupancy),   64'd1);
    drive0(1'b0, 32'h0, 4'h0); step();
    chk("s0_empty",    64'(bus0.occupancy),   64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
